// File: rtl/bias_fetch_ctrl_pkg.sv
// Shared encodings for the bias fetch controller: layer selectors, FSM states
// and the default bias word width used by b_mem.
package bias_fetch_ctrl_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        LYR_G2 = 2'd0,
        LYR_G3 = 2'd1,
        LYR_D2 = 2'd2,
        LYR_D3 = 2'd3
    } layer_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/bias_fetch_ctrl.sv
// Drives b_mem's dataset choice bits, then streams the selected layer's bias
// words one per accepted valid/ready beat and pulses done after the last one.
module bias_fetch_ctrl
    import bias_fetch_ctrl_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int N_G_L2 = 3,
    parameter int N_G_L3 = 9,
    parameter int N_D_L2 = 3,
    parameter int N_D_L3 = 1,
    parameter int IDX_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               layer_sel,
    input  logic                     set_sel,
    output logic [3:0]               choice,
    input  logic [N_G_L2*WIDTH-1:0]  bg2,
    input  logic [N_G_L3*WIDTH-1:0]  bg3,
    input  logic [N_D_L2*WIDTH-1:0]  bd2,
    input  logic [N_D_L3*WIDTH-1:0]  bd3,
    output logic [WIDTH-1:0]         bias_data,
    output logic [IDX_W-1:0]         bias_idx,
    output logic                     bias_valid,
    output logic                     bias_last,
    input  logic                     bias_ready,
    output logic                     busy,
    output logic                     done
);

    state_e             state_q, state_d;
    layer_e             layer_q, layer_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         choice_q, choice_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;

    logic               accept;
    logic               load_first;
    logic               load_next;
    logic               finish;
    logic [IDX_W-1:0]   load_idx;
    logic [WIDTH-1:0]   sel_word;

    function automatic logic [IDX_W-1:0] layer_count(input layer_e l);
        case (l)
            LYR_G2:  return IDX_W'(N_G_L2);
            LYR_G3:  return IDX_W'(N_G_L3);
            LYR_D2:  return IDX_W'(N_D_L2);
            default: return IDX_W'(N_D_L3);
        endcase
    endfunction

    assign accept     = valid_q && bias_ready;
    assign load_first = (state_q == ST_SETTLE);
    assign load_next  = (state_q == ST_STREAM) && accept && !last_q;
    assign finish     = (state_q == ST_STREAM) && accept && last_q;
    assign load_idx   = load_next ? idx_q + 1'b1 : '0;

    // Word mux indexes the bus of the latched layer; b_mem already reflects choice.
    always_comb begin
        sel_word = '0;
        case (layer_q)
            LYR_G2: for (int k = 0; k < N_G_L2; k++)
                        if (load_idx == IDX_W'(k)) sel_word = bg2[k*WIDTH +: WIDTH];
            LYR_G3: for (int k = 0; k < N_G_L3; k++)
                        if (load_idx == IDX_W'(k)) sel_word = bg3[k*WIDTH +: WIDTH];
            LYR_D2: for (int k = 0; k < N_D_L2; k++)
                        if (load_idx == IDX_W'(k)) sel_word = bd2[k*WIDTH +: WIDTH];
            default: for (int k = 0; k < N_D_L3; k++)
                        if (load_idx == IDX_W'(k)) sel_word = bd3[k*WIDTH +: WIDTH];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_STREAM;
            ST_STREAM: if (finish) state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        layer_d  = layer_q;
        cnt_d    = cnt_q;
        choice_d = choice_q;
        idx_d    = idx_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        if (state_q == ST_IDLE && start) begin
            layer_d             = layer_e'(layer_sel);
            cnt_d               = layer_count(layer_e'(layer_sel));
            choice_d[layer_sel] = set_sel;
        end
        if (load_first || load_next) begin
            idx_d   = load_idx;
            data_d  = sel_word;
            valid_d = 1'b1;
            last_d  = (load_idx == cnt_q - IDX_W'(1));
        end else if (finish) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset clears every register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_q  <= LYR_G2;
            cnt_q    <= '0;
            idx_q    <= '0;
            choice_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            layer_q  <= layer_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            choice_q <= choice_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        choice     = choice_q;
        bias_data  = data_q;
        bias_idx   = idx_q;
        bias_valid = valid_q;
        bias_last  = last_q;
    end

endmodule

// File: tb/tb_bias_fetch_ctrl.sv
// Bench for bias_fetch_ctrl: a b_mem stand-in, a transaction-level model of the
// expected beat stream, a per-cycle compare process and directed scenarios.
module tb_bias_fetch_ctrl;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    layer_sel;
    logic          set_sel;
    logic [3:0]    choice;
    logic [95:0]   bg2;
    logic [287:0]  bg3;
    logic [95:0]   bd2;
    logic [31:0]   bd3;
    logic [31:0]   bias_data;
    logic [3:0]    bias_idx;
    logic          bias_valid;
    logic          bias_last;
    logic          bias_ready;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_start = 0;
    int fv_cyc = -1;
    int done_cyc = -1;
    int done_count = 0;
    beat_t log_q[$];

    logic [31:0] g2_tab [2][3] = '{'{32'h01A1B252, 32'h00F3C2A1, 32'h00414304},
                                   '{32'hFF8E3C10, 32'h0123ABCD, 32'h00000042}};
    logic [31:0] g3_tab [2][9] = '{'{32'h00000001, 32'h00000002, 32'h00000003,
                                     32'h00000004, 32'h00000005, 32'h00000006,
                                     32'h00000007, 32'h00000008, 32'h00000009},
                                   '{32'h10000011, 32'h20000022, 32'h30000033,
                                     32'h40000044, 32'h50000055, 32'h60000066,
                                     32'h70000077, 32'h80000088, 32'hFE6F117B}};
    logic [31:0] d2_tab [2][3] = '{'{32'h025346EE, 32'h01954545, 32'hFEE8EF7B},
                                   '{32'h00A5A5A5, 32'hFF5A5A5A, 32'h01020304}};
    logic [31:0] d3_tab [2][1] = '{'{32'h00ABCDEF}, '{32'hFF43FBB5}};
    int n_of [4] = '{3, 9, 3, 1};

    bias_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer_sel(layer_sel),
        .set_sel(set_sel), .choice(choice), .bg2(bg2), .bg3(bg3), .bd2(bd2),
        .bd3(bd3), .bias_data(bias_data), .bias_idx(bias_idx),
        .bias_valid(bias_valid), .bias_last(bias_last), .bias_ready(bias_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // b_mem stand-in: each bus presents the dataset its choice bit selects.
    always_comb begin
        for (int k = 0; k < 3; k++) bg2[k*32 +: 32] = g2_tab[choice[0]][k];
        for (int k = 0; k < 9; k++) bg3[k*32 +: 32] = g3_tab[choice[1]][k];
        for (int k = 0; k < 3; k++) bd2[k*32 +: 32] = d2_tab[choice[2]][k];
        bd3 = d3_tab[choice[3]][0];
    end

    function automatic logic [31:0] tab_word(input int l, input int s, input int k);
        case (l)
            0:       return g2_tab[s][k];
            1:       return g3_tab[s][k];
            2:       return d2_tab[s][k];
            default: return d3_tab[s][k];
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a job is a queue of expected beats; valid appears two cycles after
    // the accepted start, beats pop on ready, done follows the final pop.
    logic [3:0] m_choice = '0;
    bit         m_busy = 0, m_gap = 0, m_valid = 0, m_done = 0;
    beat_t      m_exp[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_choice = '0; m_busy = 0; m_gap = 0; m_valid = 0; m_done = 0;
            m_exp.delete();
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_gap) begin
            m_gap = 0; m_valid = 1;
        end else if (m_valid) begin
            if (bias_ready) begin
                void'(m_exp.pop_front());
                if (m_exp.size() == 0) begin
                    m_valid = 0; m_done = 1;
                end
            end
        end else if (!m_busy && start) begin
            m_busy = 1; m_gap = 1;
            m_choice[layer_sel] = set_sel;
            for (int k = 0; k < n_of[layer_sel]; k++)
                m_exp.push_back('{tab_word(int'(layer_sel), int'(m_choice[layer_sel]), k),
                                  4'(k), k == n_of[layer_sel] - 1});
        end
    end

    always @(negedge clk) begin
        check("choice", {28'd0, choice}, {28'd0, m_choice});
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("valid", {31'd0, bias_valid}, {31'd0, m_valid});
        if (m_valid && m_exp.size() > 0) begin
            check("data", bias_data, m_exp[0].data);
            check("idx", {28'd0, bias_idx}, {28'd0, m_exp[0].idx});
            check("last", {31'd0, bias_last}, {31'd0, m_exp[0].last});
        end
        if (rst_n && bias_valid && fv_cyc < 0) fv_cyc = cyc;
        if (rst_n && bias_valid && bias_ready) log_q.push_back('{bias_data, bias_idx, bias_last});
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    function automatic beat_t log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l, input int s);
        start = 1'b1;
        layer_sel = 2'(l);
        set_sel = 1'(s);
        t_start = cyc;
        fv_cyc = -1;
        log_q.delete();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int i;
        d0 = done_count;
        i = 0;
        while (done_count == d0 && i < budget) begin
            tick();
            i++;
        end
        if (done_count == d0) check("done_timeout", done_count, d0 + 1);
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [3:0] p [5] = '{1, 0, 0, 1, 1};
        rst_n = 1'b0; start = 1'b0; layer_sel = '0; set_sel = 1'b0; bias_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", {31'd0, bias_valid}, 0);
        check("rst_choice", {28'd0, choice}, 0);
        rst_n = 1'b1;
        tick();

        // Layer G2, set 0, ready held high.
        bias_ready = 1'b1;
        do_start(0, 0);
        wait_done(20);
        check("t1_choice", {28'd0, choice}, 32'h0);
        check("t1_beats", log_q.size(), 3);
        check("t1_w0", log_at(0).data, 32'h01A1B252);
        check("t1_w2", log_at(2).data, 32'h00414304);
        check("t1_last", {27'd0, log_at(2).idx, log_at(2).last}, {27'd0, 4'd2, 1'b1});
        check("t1_first_lat", fv_cyc - t_start, 2);
        check("t1_done_lat", done_cyc - t_start, 5);

        // Layer G3, set 1.
        do_start(1, 1);
        wait_done(30);
        check("t2_choice", {28'd0, choice}, 32'h2);
        check("t2_beats", log_q.size(), 9);
        check("t2_w8", log_at(8).data, 32'hFE6F117B);
        check("t2_last", {27'd0, log_at(8).idx, log_at(8).last}, {27'd0, 4'd8, 1'b1});

        // Layer D3, set 1: single beat is also the last one.
        do_start(3, 1);
        wait_done(20);
        check("t3_choice", {28'd0, choice}, 32'hA);
        check("t3_beats", log_q.size(), 1);
        check("t3_w0", log_at(0).data, 32'hFF43FBB5);
        check("t3_last", {31'd0, log_at(0).last}, 1);
        check("t3_done_gap", done_cyc - fv_cyc, 1);

        // Layer D2, set 0 with back-pressure 1,0,0,1,1.
        bias_ready = 1'b0;
        do_start(2, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            bias_ready = p[i][0];
        end
        wait_done(20);
        check("t4_beats", log_q.size(), 3);
        check("t4_w0", log_at(0).data, 32'h025346EE);
        check("t4_w1", log_at(1).data, 32'h01954545);
        check("t4_w2", log_at(2).data, 32'hFEE8EF7B);
        check("t4_done_lat", done_cyc - t_start, 7);
        bias_ready = 1'b1;

        // Extra start during streaming is ignored.
        d0 = done_count;
        do_start(0, 0);
        tick(); tick();
        start = 1'b1; layer_sel = 2'd3; set_sel = 1'b0;
        tick();
        start = 1'b0;
        wait_done(20);
        repeat (4) tick();
        check("t5_beats", log_q.size(), 3);
        check("t5_dones", done_count - d0, 1);
        check("t5_choice", {28'd0, choice}, 32'hA);
        check("t5_idle", {31'd0, busy}, 0);

        // Reset after four beats of G3 abandons the stream.
        do_start(1, 1);
        repeat (5) tick();
        check("t6_beats_before", log_q.size(), 4);
        rst_n = 1'b0;
        #1;
        check("t6_valid", {31'd0, bias_valid}, 0);
        check("t6_busy", {31'd0, busy}, 0);
        check("t6_choice", {28'd0, choice}, 0);
        check("t6_data", bias_data, 0);
        check("t6_idx_last", {27'd0, bias_idx, bias_last}, 0);
        d0 = done_count;
        repeat (3) tick();
        check("t6_no_done", done_count - d0, 0);
        rst_n = 1'b1;
        tick();
        do_start(2, 1);
        wait_done(20);
        check("t6_choice_after", {28'd0, choice}, 32'h4);
        check("t6_beats_after", log_q.size(), 3);
        check("t6_w0_after", log_at(0).data, 32'h00A5A5A5);
        check("t6_done_after", done_count - d0, 1);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bias_fetch_ctrl.md
Name: bias_fetch_ctrl

Overview:
- Sequences bias delivery from the combinational b_mem bias store to the neuron accumulate stage of the generator/discriminator datapath.
- On a start request it:
  - selects the layer (G L2, G L3, D L2, D L3) and the dataset (0/1);
  - drives b_mem's choice bits;
  - slices the returned bias bus;
  - streams one WIDTH-bit bias per accepted beat over a valid/ready handshake, then reports done.

Parameters:
- WIDTH, 32, bias word width (Q8.24 signed)
- N_G_L2, 3, generator layer-2 neuron count
- N_G_L3, 9, generator layer-3 neuron count
- N_D_L2, 3, discriminator layer-2 neuron count
- N_D_L3, 1, discriminator layer-3 neuron count
- IDX_W, 4, index width; must satisfy 2**IDX_W > max(N_*)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- layer_sel  in  2  0=G L2, 1=G L3, 2=D L2, 3=D L3
- set_sel  in  1  dataset to select
- choice  out  4  to b_mem.choice; bit k = dataset of layer k
- bg2  in  N_G_L2*WIDTH  from b_mem
- bg3  in  N_G_L3*WIDTH  from b_mem
- bd2  in  N_D_L2*WIDTH  from b_mem
- bd3  in  N_D_L3*WIDTH  from b_mem
- bias_data  out  WIDTH  current bias word
- bias_idx  out  IDX_W  neuron index of bias_data
- bias_valid  out  1  beat valid
- bias_last  out  1  high with the final beat of the layer
- bias_ready  in  1  consumer accepts beat
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (async assert, sync deassert by rst_n): state=IDLE; choice=4'b0000; bias_data=0; bias_idx=0; bias_valid=0; bias_last=0; busy=0; done=0; latched layer=0; latched count=0.
- FSM states:
  - IDLE: on start=1, latch layer_sel and the count N for that layer; write set_sel into choice[layer_sel]; other choice bits are unchanged. Go to SETTLE.
  - SETTLE: 1 cycle so b_mem outputs reflect the new choice. idx=0. Go to STREAM.
  - STREAM: on entry, register bias_data = word idx of the selected bus (bits idx*WIDTH +: WIDTH); bias_valid=1; bias_last=(idx==N-1).
  - While valid && !ready: bias_data, bias_idx and bias_last hold stable.
  - On valid && ready with idx<N-1: idx++, load the next word the same cycle (back-to-back beats, 1 beat/cycle).
  - On valid && ready with bias_last: bias_valid=0, go to DONE.
  - DONE: done=1 for one cycle, busy still 1. Go to IDLE.
- Latency: start in cycle T → first bias_valid in T+2; an N-beat layer with ready held high gives done in T+2+N; busy in IDLE again at T+3+N.
- choice is registered and persists after completion; only a new start rewrites its selected bit.
- start while busy: ignored, no queuing. layer_sel and set_sel are only sampled with an accepted start.
- N=1 (D L3): the first beat has bias_last=1.
- bias_ready high outside STREAM: no effect.
- bias_data is taken unmodified from the bus; no sign extension or arithmetic.
- rst_n low mid-stream: immediate return to reset values; the partial stream is abandoned and no done is emitted.

Decomposition:
- Shared package:
  - layer encodings LYR_G2=0, LYR_G3=1, LYR_D2=2, LYR_D3=3;
  - FSM state encoding (IDLE, SETTLE, STREAM, DONE);
  - WIDTH default.
- Per-layer neuron counts stay as parameters so they match b_mem instantiation.
- No sub-module. The word-select mux is an internal function/always block; b_mem is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then start, layer_sel=0, set_sel=0, ready=1:
  - choice=4'b0000;
  - first beat bias_data=32'h01A1B252, idx 0, at T+2;
  - 3 beats, last on idx 2 = 32'h00414304;
  - done at T+5.
- start layer_sel=1, set_sel=1:
  - choice=4'b0010;
  - 9 beats, idx 8 = 32'hFE6F117B with bias_last=1.
- start layer_sel=3, set_sel=1 while choice=4'b0010:
  - choice=4'b1010;
  - single beat 32'hFF43FBB5 with bias_valid and bias_last together;
  - done next cycle.
- Layer 2, set 0 with ready toggling 1,0,0,1,1:
  - data/idx/last hold during stalls;
  - beats 32'h025346EE, 32'h01954545, 32'hFEE8EF7B appear in order, no duplicates.
- start pulsed again during STREAM of layer 0: ignored; choice unchanged; only 3 beats and one done.
- rst_n asserted after beat 4 of layer 1: all outputs zero immediately, choice=0, no done; a new start after release works normally.
